// File: rtl/cache_pkg.sv
// Shared types, widths and block word helpers for the direct-mapped write-back cache controller.
package cache_pkg;

  localparam int unsigned BLOCK_BITS  = 128;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    WB_WAIT,
    FILL,
    FILL_WAIT
  } state_t;

  // Word 0 sits in the most significant 32 bits of a block.
  function automatic logic [WORD_BITS-1:0] get_word(input logic [BLOCK_BITS-1:0] blk,
                                                    input logic [1:0] w);
    return blk[BLOCK_BITS-1-WORD_BITS*int'(w) -: WORD_BITS];
  endfunction

  function automatic logic [BLOCK_BITS-1:0] put_word(input logic [BLOCK_BITS-1:0] blk,
                                                     input logic [1:0] w,
                                                     input logic [WORD_BITS-1:0] word);
    logic [BLOCK_BITS-1:0] r;
    r = blk;
    r[BLOCK_BITS-1-WORD_BITS*int'(w) -: WORD_BITS] = word;
    return r;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage: valid/dirty bits (cleared by reset), tags and data; one async read port, one write port.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned IDX_BITS  = 3,
  parameter int unsigned TAG_BITS  = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_BITS-1:0]   rd_index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_BITS-1:0]   wr_index,
  input  logic                  wr_dirty,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_data
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_q [NUM_LINES];

  // Reset wins over a same-cycle write so an abandoned fill leaves the line invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back/write-allocate cache controller with a 128-bit block memory port.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES   = 8,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_busy,
  output logic [31:0]           mem_addr,
  output logic [BLOCK_BITS-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [BLOCK_BITS-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS = 32 - OFFSET_BITS - IDX_BITS;
  localparam int unsigned CNT_BITS = 2;

  state_t                state_q, state_next;
  logic [CNT_BITS-1:0]   cnt_q, cnt_next;
  logic                  mem_read_next, mem_write_next;
  logic [31:0]           mem_addr_next;
  logic [BLOCK_BITS-1:0] mem_wdata_next;

  logic [TAG_BITS-1:0]   req_tag;
  logic [IDX_BITS-1:0]   req_idx;
  logic [1:0]            req_word;
  logic                  req, hit;
  logic                  line_valid, line_dirty;
  logic [TAG_BITS-1:0]   line_tag;
  logic [BLOCK_BITS-1:0] line_data;
  logic                  wr_en, wr_dirty;
  logic [BLOCK_BITS-1:0] wr_data;
  logic                  hit_evt, miss_evt;
  logic                  unused_addr_bits;

  assign req_tag          = cpu_addr[31 -: TAG_BITS];
  assign req_idx          = cpu_addr[OFFSET_BITS +: IDX_BITS];
  assign req_word         = cpu_addr[3:2];
  assign unused_addr_bits = ^cpu_addr[1:0];
  assign req              = cpu_read | cpu_write;
  assign hit              = line_valid && (line_tag == req_tag);
  assign cpu_rdata        = get_word(line_data, req_word);

  cache_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_BITS  (IDX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_lines (
    .clk      (clk),
    .reset    (reset),
    .rd_index (req_idx),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_index (req_idx),
    .wr_dirty (wr_dirty),
    .wr_tag   (req_tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_next;
      cnt_q     <= cnt_next;
      mem_read  <= mem_read_next;
      mem_write <= mem_write_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
    end
  end

  // Strobes and address are registered from the transition into WRITEBACK/FILL.
  always_comb begin
    state_next     = state_q;
    cnt_next       = cnt_q;
    cpu_busy       = 1'b0;
    wr_en          = 1'b0;
    wr_dirty       = 1'b0;
    wr_data        = line_data;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    hit_evt        = 1'b0;
    miss_evt       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            hit_evt = 1'b1;
            if (cpu_write) begin
              wr_en    = 1'b1;
              wr_dirty = 1'b1;
              wr_data  = put_word(line_data, req_word, cpu_wdata);
            end
          end else begin
            cpu_busy = 1'b1;
            miss_evt = 1'b1;
            if (line_valid && line_dirty) begin
              state_next     = WRITEBACK;
              mem_write_next = 1'b1;
              mem_addr_next  = {line_tag, req_idx, 4'b0};
              mem_wdata_next = line_data;
            end else begin
              state_next    = FILL;
              mem_read_next = 1'b1;
              mem_addr_next = {req_tag, req_idx, 4'b0};
            end
          end
        end
      end
      WRITEBACK: begin
        cpu_busy   = 1'b1;
        state_next = WB_WAIT;
      end
      WB_WAIT: begin
        cpu_busy      = 1'b1;
        state_next    = FILL;
        mem_read_next = 1'b1;
        mem_addr_next = {req_tag, req_idx, 4'b0};
      end
      FILL: begin
        cpu_busy   = 1'b1;
        cnt_next   = '0;
        state_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        cpu_busy = 1'b1;
        if (cnt_q == CNT_BITS'(MEM_LATENCY - 1)) begin
          wr_en      = 1'b1;
          wr_data    = mem_rdata;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_q + CNT_BITS'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_evt)  hit_count  <= hit_count + 32'd1;
      if (miss_evt) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller (NUM_LINES=8, MEM_LATENCY=1); define CACHE_STATS_EN to check counters.
module tb_cache_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
  logic         cpu_read, cpu_write, cpu_busy, mem_write, mem_read;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int tests = 0;
  int fails = 0;
  int sb_hits = 0;
  int sb_misses = 0;

  always #5 clk = ~clk;

  cache_controller #(.NUM_LINES(8), .MEM_LATENCY(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_busy  (cpu_busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and track it cycle by cycle until the cache accepts it.
  task automatic do_access(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [31:0] wdata, output int busy_n, output int rd_n,
                           output int wr_n, output logic [31:0] raddr, output logic [31:0] waddr,
                           output logic [127:0] wblk, output logic [31:0] rdata);
    logic prev, ok, done, strobe;
    busy_n = 0; rd_n = 0; wr_n = 0;
    raddr = '0; waddr = '0; wblk = '0; rdata = '0;
    prev = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    cpu_addr = addr; cpu_read = rd; cpu_write = wr; cpu_wdata = wdata;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      strobe = mem_read | mem_write;
      ok = !(mem_read && mem_write) && !(prev && strobe) &&
           (strobe || (mem_addr == 32'd0 && mem_wdata == 128'd0));
      check("strobe_rules", 128'(ok), 128'd1);
      prev = strobe;
      if (mem_read) begin rd_n++; raddr = mem_addr; end
      if (mem_write) begin wr_n++; waddr = mem_addr; wblk = mem_wdata; end
      if (cpu_busy) busy_n++;
      else begin rdata = cpu_rdata; done = 1'b1; end
    end
    check("access_done", 128'(done), 128'd1);
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  initial begin
    int busy_n, rd_n, wr_n;
    logic [31:0] raddr, waddr, rdata;
    logic [127:0] wblk;

    reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 128'(cpu_busy), 128'd0);
    check("reset_strobes", 128'({mem_read, mem_write}), 128'd0);
    check("reset_addr", 128'(mem_addr), 128'd0);
    check("reset_wdata", mem_wdata, 128'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 128'(cpu_busy), 128'd0);

    // Clean read miss on 0x104
    mem_rdata = 128'h11111111_22222222_33333333_44444444;
    do_access(32'h0000_0104, 1'b1, 1'b0, '0, busy_n, rd_n, wr_n, raddr, waddr, wblk, rdata);
    sb_misses++; sb_hits++;
    check("clean_busy", 128'(busy_n), 128'd3);
    check("clean_nread", 128'(rd_n), 128'd1);
    check("clean_nwrite", 128'(wr_n), 128'd0);
    check("clean_raddr", 128'(raddr), 128'h100);
    check("clean_rdata", 128'(rdata), 128'h22222222);

    // Write hit then read back
    do_access(32'h0000_0108, 1'b0, 1'b1, 32'hDEADBEEF, busy_n, rd_n, wr_n, raddr, waddr, wblk, rdata);
    sb_hits++;
    check("whit_busy", 128'(busy_n), 128'd0);
    check("whit_strobes", 128'(rd_n + wr_n), 128'd0);
    do_access(32'h0000_0108, 1'b1, 1'b0, '0, busy_n, rd_n, wr_n, raddr, waddr, wblk, rdata);
    sb_hits++;
    check("rhit_busy", 128'(busy_n), 128'd0);
    check("rhit_strobes", 128'(rd_n + wr_n), 128'd0);
    check("rhit_rdata", 128'(rdata), 128'hDEADBEEF);
    do_access(32'h0000_010C, 1'b1, 1'b0, '0, busy_n, rd_n, wr_n, raddr, waddr, wblk, rdata);
    sb_hits++;
    check("rhit_w3", 128'(rdata), 128'h44444444);

    // Dirty eviction: same index, new tag
    mem_rdata = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
    do_access(32'h0000_0188, 1'b1, 1'b0, '0, busy_n, rd_n, wr_n, raddr, waddr, wblk, rdata);
    sb_misses++; sb_hits++;
    check("dirty_busy", 128'(busy_n), 128'd5);
    check("dirty_nwrite", 128'(wr_n), 128'd1);
    check("dirty_waddr", 128'(waddr), 128'h100);
    check("dirty_wdata", wblk, 128'h11111111_22222222_DEADBEEF_44444444);
    check("dirty_nread", 128'(rd_n), 128'd1);
    check("dirty_raddr", 128'(raddr), 128'h180);
    check("dirty_rdata", 128'(rdata), 128'hCCCC2222);

    // Read and write together on a hit line act as a write
    do_access(32'h0000_018C, 1'b1, 1'b1, 32'h0BADF00D, busy_n, rd_n, wr_n, raddr, waddr, wblk, rdata);
    sb_hits++;
    check("rw_busy", 128'(busy_n), 128'd0);
    check("rw_strobes", 128'(rd_n + wr_n), 128'd0);
    do_access(32'h0000_018C, 1'b1, 1'b0, '0, busy_n, rd_n, wr_n, raddr, waddr, wblk, rdata);
    sb_hits++;
    check("rw_readback", 128'(rdata), 128'h0BADF00D);
    do_access(32'h0000_0180, 1'b1, 1'b0, '0, busy_n, rd_n, wr_n, raddr, waddr, wblk, rdata);
    sb_hits++;
    check("rw_other_word", 128'(rdata), 128'hAAAA0000);

`ifdef CACHE_STATS_EN
    @(negedge clk);
    check("stats_hits_pre", 128'(hit_count), 128'(sb_hits));
    check("stats_misses_pre", 128'(miss_count), 128'(sb_misses));
`endif

    // Reset while in FILL_WAIT on a clean miss at index 1
    mem_rdata = 128'h55555555_66666666_77777777_88888888;
    @(posedge clk); #1;
    cpu_addr = 32'h0000_0214; cpu_read = 1'b1;
    @(negedge clk);
    check("rst_miss_busy", 128'(cpu_busy), 128'd1);
    @(negedge clk);
    check("rst_fill_read", 128'(mem_read), 128'd1);
    check("rst_fill_addr", 128'(mem_addr), 128'h210);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_fw_busy", 128'(cpu_busy), 128'd1);
    @(posedge clk); #1;
    reset = 1'b0; cpu_read = 1'b0;
    sb_hits = 0; sb_misses = 0;
    @(negedge clk);
    check("rst_after_strobes", 128'({mem_read, mem_write}), 128'd0);
    check("rst_after_busy", 128'(cpu_busy), 128'd0);
    check("rst_after_addr", 128'(mem_addr), 128'd0);

    do_access(32'h0000_0214, 1'b1, 1'b0, '0, busy_n, rd_n, wr_n, raddr, waddr, wblk, rdata);
    sb_misses++; sb_hits++;
    check("rerd_busy", 128'(busy_n), 128'd3);
    check("rerd_nread", 128'(rd_n), 128'd1);
    check("rerd_raddr", 128'(raddr), 128'h210);
    check("rerd_rdata", 128'(rdata), 128'h66666666);

    // Previously dirty line 0 must now miss cleanly
    do_access(32'h0000_0188, 1'b1, 1'b0, '0, busy_n, rd_n, wr_n, raddr, waddr, wblk, rdata);
    sb_misses++; sb_hits++;
    check("post_rst_busy", 128'(busy_n), 128'd3);
    check("post_rst_nwrite", 128'(wr_n), 128'd0);
    check("post_rst_rdata", 128'(rdata), 128'h77777777);

    // No request keeps the controller idle
    repeat (3) begin
      @(negedge clk);
      check("noreq_idle", 128'({cpu_busy, mem_read, mem_write}), 128'd0);
    end

`ifdef CACHE_STATS_EN
    check("stats_hits", 128'(hit_count), 128'(sb_hits));
    check("stats_misses", 128'(miss_count), 128'(sb_misses));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
